// File: rtl/alu_pkg.sv
// Shared encodings, operation/state enums and the ALUOp/funct decoder for the EX-stage ALU.
package alu_pkg;

  localparam logic [1:0] AluOpMem    = 2'b00;
  localparam logic [1:0] AluOpBranch = 2'b01;
  localparam logic [1:0] AluOpRtype  = 2'b10;
  localparam logic [1:0] AluOpRsvd   = 2'b11;

  localparam logic [6:0] F7Base   = 7'b0000000;
  localparam logic [6:0] F7Alt    = 7'b0100000;
  localparam logic [6:0] F7MulDiv = 7'b0000001;

  typedef enum logic [3:0] {
    OpAdd, OpSub, OpSll, OpSlt, OpXor, OpSrl, OpSra, OpOr, OpAnd,
    OpMul, OpMulh, OpMulhu, OpDiv, OpDivu, OpRem, OpRemu
  } alu_op_e;

  typedef enum logic [1:0] {StIdle, StMul, StDiv, StDone} state_e;

  typedef enum logic {KindMul, KindDiv} md_kind_e;

  function automatic alu_op_e decode_op(input logic [1:0] alu_op, input logic [6:0] f7,
                                        input logic [2:0] f3);
    alu_op_e op;
    op = OpAdd;
    case (alu_op)
      AluOpMem:    if (f3 == 3'b101 && f7 == F7Alt) op = OpSra;
      AluOpBranch: op = OpSub;
      AluOpRsvd:   op = OpAdd;
      AluOpRtype: begin
        case (f7)
          F7Base: begin
            case (f3)
              3'b001:  op = OpSll;
              3'b010:  op = OpSlt;
              3'b100:  op = OpXor;
              3'b101:  op = OpSrl;
              3'b110:  op = OpOr;
              3'b111:  op = OpAnd;
              default: op = OpAdd;
            endcase
          end
          F7Alt: begin
            if (f3 == 3'b000) op = OpSub;
            else if (f3 == 3'b101) op = OpSra;
          end
          F7MulDiv: begin
            case (f3)
              3'b000:  op = OpMul;
              3'b001:  op = OpMulh;
              3'b011:  op = OpMulhu;
              3'b100:  op = OpDiv;
              3'b101:  op = OpDivu;
              3'b110:  op = OpRem;
              3'b111:  op = OpRemu;
              default: op = OpAdd;
            endcase
          end
          default: op = OpAdd;
        endcase
      end
      default: op = OpAdd;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_exec_ctrl_if.sv
// Operand/result handshake bundle between the ID/EX register side and the execute block.
interface alu_exec_ctrl_if #(
  parameter int unsigned XLEN = 32
);
  logic            valid_i;
  logic            ready_o;
  logic            flush_i;
  logic [1:0]      ALUOp_i;
  logic [6:0]      funct7_i;
  logic [2:0]      funct3_i;
  logic [XLEN-1:0] a_i;
  logic [XLEN-1:0] b_i;
  logic [XLEN-1:0] result_o;
  logic            valid_o;
  logic            busy_o;

  modport master (
    output valid_i, flush_i, ALUOp_i, funct7_i, funct3_i, a_i, b_i,
    input  ready_o, result_o, valid_o, busy_o
  );

  modport slave (
    input  valid_i, flush_i, ALUOp_i, funct7_i, funct3_i, a_i, b_i,
    output ready_o, result_o, valid_o, busy_o
  );
endinterface

// File: rtl/muldiv_iter.sv
// Iterative unsigned datapath: radix-2 shift-add multiply and restoring divide, one bit per cycle.
module muldiv_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  md_kind_e          kind_i,
  input  logic              flush_i,
  input  logic [XLEN-1:0]   opa_i,
  input  logic [XLEN-1:0]   opb_i,
  output logic              done_o,
  output logic [2*XLEN-1:0] result_o
);

  // hi: product high half / partial remainder; lo: multiplier / dividend shifting into quotient.
  logic [XLEN-1:0] hi_q, lo_q, opnd_q;
  logic [SHW-1:0]  cnt_q;
  md_kind_e        kind_q;
  logic            active_q;

  logic [XLEN:0]     mul_sum, div_shift, div_diff;
  logic [2*XLEN-1:0] mul_next, div_next;

  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    mul_next  = {mul_sum, lo_q[XLEN-1:1]};
    div_shift = {hi_q, lo_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_next  = div_diff[XLEN] ? {div_shift[XLEN-1:0], lo_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], lo_q[XLEN-2:0], 1'b1};
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      kind_q   <= KindMul;
      active_q <= 1'b0;
    end else if (flush_i) begin
      active_q <= 1'b0;
    end else if (start_i) begin
      hi_q     <= '0;
      lo_q     <= opa_i;
      opnd_q   <= opb_i;
      cnt_q    <= SHW'(XLEN - 1);
      kind_q   <= kind_i;
      active_q <= 1'b1;
    end else if (active_q) begin
      {hi_q, lo_q} <= (kind_q == KindMul) ? mul_next : div_next;
      if (cnt_q == '0) active_q <= 1'b0;
      else cnt_q <= cnt_q - 1'b1;
    end
  end

  // High during the final iteration; result_o is complete after this edge.
  assign done_o   = active_q && (cnt_q == '0);
  assign result_o = {hi_q, lo_q};

endmodule

// File: rtl/alu_exec_ctrl.sv
// EX-stage ALU: decodes ALUOp/funct fields, executes single-cycle ops and sequences RV32M ops.
module alu_exec_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned SHW  = $clog2(XLEN)
) (
  input logic           clk_i,
  input logic           rst_n_i,
  alu_exec_ctrl_if.slave bus
);

  state_e          state_q;
  alu_op_e         op_q;
  logic            neg_q, valid_q, busy_q;
  logic [XLEN-1:0] result_q;

  logic [XLEN-1:0] a, b, a_mag, b_mag, single_res, special_res, fixed_res, raw_hi, raw_lo;
  logic [XLEN-1:0] min_neg, mulh_neg;
  logic [SHW-1:0]  shamt;
  alu_op_e         op;
  logic            accept, is_mul, is_div, is_signed, a_neg, b_neg, neg_d;
  logic            div_zero, div_ovf, multi, iter_done;
  logic [2*XLEN-1:0] raw;

  assign a       = bus.a_i;
  assign b       = bus.b_i;
  assign shamt   = b[SHW-1:0];
  assign min_neg = {1'b1, {(XLEN-1){1'b0}}};
  assign op      = decode_op(bus.ALUOp_i, bus.funct7_i, bus.funct3_i);
  assign accept  = bus.valid_i && !busy_q && !bus.flush_i;

  assign is_mul    = op inside {OpMul, OpMulh, OpMulhu};
  assign is_div    = op inside {OpDiv, OpDivu, OpRem, OpRemu};
  assign is_signed = op inside {OpMulh, OpDiv, OpRem};
  assign a_neg     = is_signed && a[XLEN-1];
  assign b_neg     = is_signed && b[XLEN-1];
  assign a_mag     = a_neg ? -a : a;
  assign b_mag     = b_neg ? -b : b;
  assign neg_d     = (op == OpRem) ? a_neg : (a_neg ^ b_neg);

  assign div_zero = is_div && (b == '0);
  assign div_ovf  = (op inside {OpDiv, OpRem}) && (a == min_neg) && (b == '1);
  assign multi    = (is_mul || is_div) && !div_zero && !div_ovf;

  always_comb begin
    if (op inside {OpDiv, OpDivu}) special_res = div_zero ? '1 : a;
    else special_res = div_zero ? a : '0;

    case (op)
      OpAdd:   single_res = a + b;
      OpSub:   single_res = a - b;
      OpSll:   single_res = a << shamt;
      OpSlt:   single_res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OpXor:   single_res = a ^ b;
      OpSrl:   single_res = a >> shamt;
      OpSra:   single_res = $unsigned($signed(a) >>> shamt);
      OpOr:    single_res = a | b;
      OpAnd:   single_res = a & b;
      default: single_res = special_res;
    endcase
  end

  muldiv_iter #(
    .XLEN (XLEN),
    .SHW  (SHW)
  ) u_iter (
    .clk_i    (clk_i),
    .rst_n_i  (rst_n_i),
    .start_i  (accept && multi),
    .kind_i   (is_mul ? KindMul : KindDiv),
    .flush_i  (bus.flush_i),
    .opa_i    (a_mag),
    .opb_i    (b_mag),
    .done_o   (iter_done),
    .result_o (raw)
  );

  assign raw_hi = raw[2*XLEN-1:XLEN];
  assign raw_lo = raw[XLEN-1:0];
  // High half of the negated 2*XLEN product: borrow only propagates when the low half is zero.
  assign mulh_neg = ~raw_hi + {{(XLEN-1){1'b0}}, raw_lo == '0};

  always_comb begin
    case (op_q)
      OpMul:   fixed_res = raw_lo;
      OpMulh:  fixed_res = neg_q ? mulh_neg : raw_hi;
      OpMulhu: fixed_res = raw_hi;
      OpDiv:   fixed_res = neg_q ? -raw_lo : raw_lo;
      OpRem:   fixed_res = neg_q ? -raw_hi : raw_hi;
      OpRemu:  fixed_res = raw_hi;
      default: fixed_res = raw_lo;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      op_q     <= OpAdd;
      neg_q    <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (accept) begin
            if (multi) begin
              state_q <= is_mul ? StMul : StDiv;
              busy_q  <= 1'b1;
              op_q    <= op;
              neg_q   <= neg_d;
            end else begin
              result_q <= single_res;
              valid_q  <= 1'b1;
            end
          end
        end
        StMul, StDiv: begin
          if (bus.flush_i) begin
            state_q <= StIdle;
            busy_q  <= 1'b0;
          end else if (iter_done) begin
            state_q <= StDone;
          end
        end
        StDone: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          if (!bus.flush_i) begin
            result_q <= fixed_res;
            valid_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.result_o = result_q;
  assign bus.valid_o  = valid_q;
  assign bus.busy_o   = busy_q;
  assign bus.ready_o  = !busy_q;

endmodule
